// File: rtl/pwmencoder_wb.sv
// pwmencoder_wb: six-channel frame-synchronous PWM generator with a Wishbone register interface.
module pwmencoder_wb #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int CLKS_PER_US  = 48
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [5:0]              wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  input  logic                    wb_cyc_i,
  output logic [5:0]              pwm_o
);
  localparam int PW = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(CLKS_PER_US - 1);
  logic [15:0] width_q [6];
  logic [15:0] width_d [6];
  logic [15:0] sh_width_q [6];
  logic [15:0] sh_width_d [6];
  logic [15:0] period_q, period_d, sh_period_q, sh_period_d, fcnt_q, fcnt_d, pmerge;
  logic [PW-1:0] psc_q, psc_d;
  logic [31:0] status_q, status_d, dat_d, rdata;
  logic [5:0] pwm_d;
  logic [3:0] a;
  logic en_q, en_d, start, wr, tick, wrap, reload;
  logic unused_ok;
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] s);
    return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
  endfunction
  assign unused_ok = ^{wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2], 1'(ADDR_WIDTH)};
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign a = wb_adr_i[5:2];
  assign start = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr = start & wb_we_i;
  assign tick = en_q & (psc_q == PSC_MAX);
  assign wrap = tick & (fcnt_q == sh_period_q - 16'd1);
  // shadows track the live registers while idle so enabling starts from current values
  assign reload = ~en_q | wrap;
  assign pmerge = merge(period_q, wb_dat_i[15:0], wb_sel_i[1:0]);
  assign rdata = a < 4'd6  ? {16'h0, width_q[a[2:0]]} :
                 a == 4'd6 ? {16'h0, period_q} :
                 a == 4'd7 ? {31'h0, en_q} :
                 a == 4'd8 ? status_q : '1;
  assign period_d = wr && a == 4'd6 && pmerge != 16'd0 ? pmerge : period_q;
  assign en_d = wr && a == 4'd7 && wb_sel_i[0] ? wb_dat_i[0] : en_q;
  assign dat_d = start ? rdata : wb_dat_o;
  assign psc_d = en_q && !tick ? psc_q + 1'b1 : '0;
  assign fcnt_d = reload ? '0 : tick ? fcnt_q + 16'd1 : fcnt_q;
  assign sh_period_d = reload ? period_q : sh_period_q;
  assign status_d = status_q + {31'h0, wrap};
  always_comb begin
    for (int n = 0; n < 6; n++) begin
      width_d[n] = wr && a == 4'(n) ? merge(width_q[n], wb_dat_i[15:0], wb_sel_i[1:0]) : width_q[n];
      sh_width_d[n] = reload ? width_q[n] : sh_width_q[n];
      pwm_d[n] = en_q & (fcnt_q < sh_width_q[n]);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 6; n++) begin
        width_q[n] <= 16'd1000;
        sh_width_q[n] <= 16'd1000;
      end
      period_q <= 16'd20000;
      sh_period_q <= 16'd20000;
      en_q <= 1'b0;
      status_q <= '0;
      psc_q <= '0;
      fcnt_q <= '0;
      pwm_o <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      width_q <= width_d;
      sh_width_q <= sh_width_d;
      period_q <= period_d;
      sh_period_q <= sh_period_d;
      en_q <= en_d;
      status_q <= status_d;
      psc_q <= psc_d;
      fcnt_q <= fcnt_d;
      pwm_o <= pwm_d;
      wb_ack_o <= start;
      wb_dat_o <= dat_d;
    end
  end
endmodule

// File: tb/tb_pwmencoder_wb.sv
// tb_pwmencoder_wb: directed and randomized checks of pwmencoder_wb against a cycle-position model.
module tb_pwmencoder_wb;
  localparam int C = 2;
  logic clk = 0, rst = 1, we = 0, stb = 0, cyc = 0;
  logic [5:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0] sel = '0;
  logic [31:0] dat_o;
  logic ack, err, rty;
  logic [5:0] pwm;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_w [6];
  logic [31:0] m_sw [6];
  logic [31:0] m_p, m_sp, m_st, m_rd;
  int m_pos;
  bit m_en, m_ack;
  logic [5:0] m_pwm;
  logic [31:0] q, s0;
  int cnt0, cnt1, cnt2, len;
  bit ok;

  pwmencoder_wb #(.CLKS_PER_US(C)) dut (
    .i_clk(clk), .i_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .wb_cyc_i(cyc), .pwm_o(pwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    return {16'h0, s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
  endfunction

  // Model: a frame is period*C clock cycles; a channel is high while the cycle position is below width*C.
  task automatic model_edge();
    logic s;
    logic [31:0] r, v;
    logic [5:0] np;
    int a;
    if (rst) begin
      for (int n = 0; n < 6; n++) begin m_w[n] = 1000; m_sw[n] = 1000; end
      m_p = 20000; m_sp = 20000; m_en = 0; m_st = 0; m_pos = 0;
      m_ack = 0; m_rd = 0; m_pwm = 0;
      return;
    end
    s = stb & cyc & !m_ack;
    a = int'(adr[5:2]);
    if (a < 6) r = m_w[a];
    else if (a == 6) r = m_p;
    else if (a == 7) r = {31'h0, m_en};
    else if (a == 8) r = m_st;
    else r = '1;
    for (int n = 0; n < 6; n++) np[n] = m_en && (m_pos < int'(m_sw[n]) * C);
    if (m_en) begin
      m_pos++;
      if (m_pos == int'(m_sp) * C) begin m_pos = 0; m_sw = m_w; m_sp = m_p; m_st++; end
    end else begin
      m_pos = 0; m_sw = m_w; m_sp = m_p;
    end
    m_pwm = np;
    m_ack = s;
    if (s) m_rd = r;
    if (s && we) begin
      if (a < 6) m_w[a] = mrg(m_w[a], dat, sel);
      else if (a == 6) begin v = mrg(m_p, dat, sel); if (v != 0) m_p = v; end
      else if (a == 7 && sel[0]) m_en = dat[0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", {31'h0, ack}, {31'h0, m_ack});
    chk("pwm", {26'h0, pwm}, {26'h0, m_pwm});
    if (m_ack) chk("rdata", dat_o, m_rd);
  endtask

  task automatic acc(input bit w, input logic [5:0] ad, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    stb = 1; cyc = 1; we = w; adr = ad; dat = d; sel = s;
    step();
    r = dat_o;
    stb = 0; cyc = 0; we = 0;
    step();
  endtask

  task automatic wr(input logic [5:0] ad, input logic [31:0] d);
    logic [31:0] r;
    acc(1, ad, d, 4'hF, r);
  endtask

  initial begin
    step(); step();
    rst = 0;
    step();
    chk("err_tied", {31'h0, err}, 32'h0);
    chk("rty_tied", {31'h0, rty}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      acc(0, 6'(i * 4), 0, 0, q);
      chk($sformatf("reset_rd%0d", i), q, i < 6 ? 32'd1000 : i == 6 ? 32'd20000 : i == 9 ? 32'hFFFFFFFF : 32'h0);
      chk("ack_one_cycle", {31'h0, ack}, 32'h0);
    end
    wr(6'h18, 10); wr(6'h00, 3); wr(6'h04, 0); wr(6'h08, 10); wr(6'h1C, 1);
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cnt0 += int'(pwm[0]); cnt1 += int'(pwm[1]); cnt2 += int'(pwm[2]);
    end
    chk("ch0_high", cnt0, 12);
    chk("ch1_high", cnt1, 0);
    chk("ch2_high", cnt2, 40);
    acc(0, 6'h20, 0, 0, q);
    chk("status_two_frames", q, 2);
    wr(6'h00, 7);
    len = 0;
    for (int i = 0; i < 40; i++) begin step(); if (!pwm[0]) break; len++; end
    chk("cur_frame_tail", len, 1);
    ok = 0;
    for (int i = 0; i < 60; i++) begin if (pwm[0]) begin ok = 1; break; end step(); end
    chk("rise_timeout", {31'h0, ok}, 1);
    len = 0;
    for (int i = 0; i < 60; i++) begin if (!pwm[0]) break; len++; step(); end
    chk("next_frame_pulse", len, 14);
    wr(6'h0C, 0);
    acc(1, 6'h0C, 32'hFFFF0005, 4'b0001, q);
    acc(0, 6'h0C, 0, 0, q);
    chk("sel_byte_write", q, 5);
    wr(6'h18, 0);
    acc(0, 6'h18, 0, 0, q);
    chk("period_zero_ignored", q, 10);
    ok = 0;
    for (int i = 0; i < 60; i++) begin if (pwm[0]) begin ok = 1; break; end step(); end
    chk("pulse_timeout", {31'h0, ok}, 1);
    wr(6'h1C, 0);
    chk("pwm_off", {26'h0, pwm}, 0);
    acc(0, 6'h20, 0, 0, s0);
    for (int i = 0; i < 10; i++) step();
    wr(6'h1C, 1);
    chk("restart", {26'h0, pwm}, 32'h3D);
    len = 0;
    for (int i = 0; i < 60; i++) begin if (!pwm[0]) break; len++; step(); end
    chk("restart_pulse", len, 14);
    acc(0, 6'h20, 0, 0, q);
    chk("status_held", q, s0);
    for (int i = 0; i < 60; i++) begin
      acc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom & 32'hFFFF001F, 4'($urandom), q);
      for (int k = $urandom_range(0, 15); k > 0; k--) step();
    end
    wr(6'h18, 10); wr(6'h00, 4); wr(6'h1C, 1);
    for (int i = 0; i < 7; i++) step();
    stb = 1; cyc = 1; we = 1; adr = 6'h00; dat = 9; sel = 4'hF; rst = 1;
    step();
    rst = 0; stb = 0; cyc = 0; we = 0;
    step();
    chk("rst_pwm", {26'h0, pwm}, 0);
    acc(0, 6'h00, 0, 0, q);
    chk("rst_width0", q, 1000);
    acc(0, 6'h18, 0, 0, q);
    chk("rst_period", q, 20000);
    acc(0, 6'h1C, 0, 0, q);
    chk("rst_ctrl", q, 0);
    acc(0, 6'h20, 0, 0, q);
    chk("rst_status", q, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwmencoder_wb.md
PWMENCODER_WB -- requirements
Module: pwmencoder_wb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, nominal address width; only 6 address bits are decoded.
REQ-003 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter CLKS_PER_US, default 48, i_clk cycles per 1 us tick; minimum 1.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port wb_adr_i, input, 6, byte address; bits [1:0] ignored.
REQ-009 SHALL have port wb_dat_i, input, DATA_WIDTH, write data.
REQ-010 SHALL have port wb_dat_o, output, DATA_WIDTH, read data.
REQ-011 SHALL have port wb_we_i, input, 1, write enable.
REQ-012 SHALL have port wb_sel_i, input, SELECT_WIDTH, byte lane enables for writes.
REQ-013 SHALL have port wb_stb_i, input, 1, strobe.
REQ-014 SHALL have port wb_ack_o, output, 1, acknowledge.
REQ-015 SHALL have port wb_err_o, output, 1, tied 0.
REQ-016 SHALL have port wb_rty_o, output, 1, tied 0.
REQ-017 SHALL have port wb_cyc_i, input, 1, cycle.
REQ-018 SHALL have port pwm_o, output, 6, PWM outputs, bit n = channel n.

Function
REQ-019 SHALL use this register map (word offsets): 0x00-0x14 WIDTH0-5 [15:0] us; 0x18 PERIOD [15:0] us; 0x1C CTRL bit0 EN; 0x20 STATUS [31:0] frame count (read-only).
REQ-020 SHALL read unused upper bits of WIDTH, PERIOD and CTRL as 0.
REQ-021 SHALL return 0xFFFFFFFF for reads of unmapped addresses and ignore writes to them or to STATUS.
REQ-022 SHALL start an access on a clock edge where wb_stb_i & wb_cyc_i & ~wb_ack_o.
REQ-023 SHALL register wb_ack_o high for exactly one cycle on the edge after an access starts; back-to-back accesses therefore ack every other cycle.
REQ-024 SHALL perform writes on the access-start edge, updating only the bytes whose wb_sel_i bit is set.
REQ-025 SHALL register read data on the access-start edge, valid while wb_ack_o is high.
REQ-026 SHALL ignore a PERIOD write whose resulting value is 0; the previous value is retained.
REQ-027 SHALL generate a one-cycle tick every CLKS_PER_US cycles using a prescaler counting 0..CLKS_PER_US-1, while EN=1.
REQ-028 SHALL count frame_cnt 0..shadow_period-1 on ticks; the tick at shadow_period-1 wraps it to 0 and marks the frame boundary.
REQ-029 SHALL, at each frame boundary, copy WIDTH0-5 and PERIOD into shadow registers and increment STATUS (mod 2^32).
REQ-030 SHALL never let a mid-frame register write alter the current frame; the new value takes effect from the next frame.
REQ-031 SHALL register pwm_o[n] <= EN & (frame_cnt < shadow_width[n]), one cycle of latency behind frame_cnt.
REQ-032 SHALL hold pwm_o[n] low for a whole frame when its width is 0.
REQ-033 SHALL hold pwm_o[n] high for a whole frame when its width >= shadow_period, with no low glitch at wrap.
REQ-034 SHALL, while EN=0, hold the prescaler and frame_cnt at 0, drive pwm_o to 0, and load shadows from the live registers every cycle.
REQ-035 SHALL, when EN goes 0->1, start frame 0 on the next cycle with the current register values and all channels of non-zero width high.
REQ-036 SHALL, when EN goes 1->0, drive pwm_o low on the next cycle and leave STATUS unchanged.

Reset
REQ-037 SHALL, on i_rst=1, set WIDTH0-5 to 1000, PERIOD to 20000, EN to 0, STATUS to 0, prescaler, frame_cnt, pwm_o, wb_ack_o and wb_dat_o to 0, and shadows to the reset register values.
REQ-038 SHALL, on reset asserted mid-frame or mid-access, take reset values on that edge, drop any pending ack, and discard any write.

Verification (CLKS_PER_US=2)
REQ-039 SHALL verify: after reset, read every map address -> WIDTHn=1000, PERIOD=20000, CTRL=0, STATUS=0, 0x24=0xFFFFFFFF; ack is one cycle per access.
REQ-040 SHALL verify: write PERIOD=10, WIDTH0=3, WIDTH1=0, WIDTH2=10, then EN=1 -> ch0 high 6 cycles of 20, ch1 always low, ch2 always high, STATUS +1 every 20 cycles.
REQ-041 SHALL verify: mid-frame write WIDTH0=7 -> current frame keeps a 6-cycle high pulse and the next frame has 14 cycles high.
REQ-042 SHALL verify: write 0xFFFF0005 to WIDTH3 with wb_sel_i=0001 -> readback 0x00000005; a PERIOD write of 0 -> PERIOD unchanged.
REQ-043 SHALL verify: EN=0 mid-pulse -> pwm_o=0 next cycle; EN=1 again -> frame_cnt restarts at 0 and STATUS has not incremented.
REQ-044 SHALL verify: i_rst pulsed during an active frame and a pending write -> all values return to reset, the write is lost, and pwm_o=0.
